// File: rtl/seg7_reader.sv
// Seven-segment bus reader: waits for a stable digit pattern on a
// multiplexed active-low display bus and decodes it back to hex.
module seg7_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    cap_stb,
    output logic [2:0]              cap_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    function automatic logic f_onehot_low(input logic [NUM_DIGITS-1:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n = n + {3'b000, ~d[i]};
        end
        return (n == 4'd1);
    endfunction

    // Returns {legal, value} for an active-high gfedcba pattern
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h67:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig;
    logic [7:0]              r_cnt;
    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_err;
    logic                    r_stb;
    logic [2:0]              r_idx;

    logic       w_change;
    logic       w_onehot_in;
    logic [7:0] w_cnt_next;
    state_t     w_state_next;
    logic       w_capture;
    logic [2:0] w_idx;
    logic [4:0] w_dec;
    logic       w_blank;

    assign w_change    = (seg_n != r_seg) || (dig_n != r_dig);
    assign w_onehot_in = f_onehot_low(dig_n);
    assign w_dec       = f_decode(~r_seg);
    assign w_blank     = (r_seg == 7'h7F);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_change) begin
            w_cnt_next = w_onehot_in ? 8'd1 : 8'd0;
        end else if (r_cnt != 8'd0 && r_cnt != 8'hFF) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // A change on the capture edge itself abandons the window
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (w_change) begin
            if (!w_onehot_in) begin
                w_state_next = ST_IDLE;
            end else if (LP_STABLE == 8'd1) begin
                w_state_next = ST_CAPTURE;
            end else begin
                w_state_next = ST_COUNT;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: w_state_next = ST_IDLE;
                ST_COUNT: begin
                    if (w_cnt_next == LP_STABLE) begin
                        w_state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
                ST_HOLD: w_state_next = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_dig[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg   <= 7'h7F;
            r_dig   <= '1;
            r_cnt   <= 8'd0;
            r_state <= ST_IDLE;
        end else begin
            r_seg   <= seg_n;
            r_dig   <= dig_n;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex   <= '0;
            r_valid <= '0;
            r_blank <= '0;
            r_err   <= '0;
            r_stb   <= 1'b0;
            r_idx   <= 3'd0;
        end else begin
            r_stb <= w_capture;
            if (w_capture) begin
                r_idx <= w_idx;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_capture && !r_dig[i]) begin
                    if (w_dec[4]) begin
                        r_hex[4*i +: 4] <= w_dec[3:0];
                    end
                    r_valid[i] <= w_dec[4];
                    r_blank[i] <= w_blank;
                    r_err[i]   <= !w_dec[4] && !w_blank;
                end
            end
        end
    end

    assign hex_out     = r_hex;
    assign digit_valid = r_valid;
    assign digit_blank = r_blank;
    assign digit_err   = r_err;
    assign cap_stb     = r_stb;
    assign cap_idx     = r_idx;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: stimulus pushes expected captures,
// a monitor pops and compares on every cap_stb.
module tb_seg7_reader;

    localparam int ND = 4;
    localparam int N  = 4;

    logic          clk;
    logic          reset_n;
    logic [6:0]    seg_n;
    logic [ND-1:0] dig_n;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] digit_blank;
    logic [ND-1:0] digit_err;
    logic          cap_stb;
    logic [2:0]    cap_idx;

    seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .digit_err   (digit_err),
        .cap_stb     (cap_stb),
        .cap_idx     (cap_idx)
    );

    typedef struct {
        int              cyc;
        logic [2:0]      idx;
        logic [4*ND-1:0] hex;
        logic [ND-1:0]   v;
        logic [ND-1:0]   b;
        logic [ND-1:0]   e;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]   m_v;
    logic [ND-1:0]   m_b;
    logic [ND-1:0]   m_e;
    logic [6:0]      pat [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (cap_stb !== 1'b0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cap: got cap_stb=%b idx=%0d expected none at cycle %0d",
                         cap_stb, cap_idx, cyc);
            end else begin
                e = q.pop_front();
                chk("cap_cycle", 32'(cyc), 32'(e.cyc));
                chk("cap_idx", {29'd0, cap_idx}, {29'd0, e.idx});
                chk("cap_hex", {16'd0, hex_out}, {16'd0, e.hex});
                chk("cap_valid", {28'd0, digit_valid}, {28'd0, e.v});
                chk("cap_blank", {28'd0, digit_blank}, {28'd0, e.b});
                chk("cap_err", {28'd0, digit_err}, {28'd0, e.e});
            end
        end
    end

    task automatic expect_cap(input logic [ND-1:0] d, input logic [6:0] p,
                              input int at);
        exp_t e;
        int   idx;
        int   val;
        idx = 0;
        val = -1;
        for (int i = 0; i < ND; i++) if (!d[i]) idx = i;
        for (int j = 0; j < 16; j++) if (pat[j] == p) val = j;
        if (val >= 0) begin
            m_hex[4*idx +: 4] = 4'(val);
            m_v[idx] = 1'b1; m_b[idx] = 1'b0; m_e[idx] = 1'b0;
        end else if (p == 7'h00) begin
            m_v[idx] = 1'b0; m_b[idx] = 1'b1; m_e[idx] = 1'b0;
        end else begin
            m_v[idx] = 1'b0; m_b[idx] = 1'b0; m_e[idx] = 1'b1;
        end
        e.cyc = at;
        e.idx = 3'(idx);
        e.hex = m_hex;
        e.v   = m_v;
        e.b   = m_b;
        e.e   = m_e;
        q.push_back(e);
    endtask

    // Drive at a negedge and hold for n rising edges
    task automatic apply(input logic [ND-1:0] d, input logic [6:0] p,
                         input int n);
        int k;
        dig_n = d;
        seg_n = ~p;
        k = cyc + 1;
        if ($countones(~d) == 1 && n >= N + 1) expect_cap(d, p, k + N);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_hex"}, {16'd0, hex_out}, {16'd0, m_hex});
        chk({tag, "_valid"}, {28'd0, digit_valid}, {28'd0, m_v});
        chk({tag, "_blank"}, {28'd0, digit_blank}, {28'd0, m_b});
        chk({tag, "_err"}, {28'd0, digit_err}, {28'd0, m_e});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hex"}, {16'd0, hex_out}, 32'd0);
        chk({tag, "_valid"}, {28'd0, digit_valid}, 32'd0);
        chk({tag, "_blank"}, {28'd0, digit_blank}, 32'd0);
        chk({tag, "_err"}, {28'd0, digit_err}, 32'd0);
        chk({tag, "_stb"}, {31'd0, cap_stb}, 32'd0);
        chk({tag, "_idx"}, {29'd0, cap_idx}, 32'd0);
    endtask

    initial begin
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        cyc = 0; n_cmp = 0; n_bad = 0;
        m_hex = '0; m_v = '0; m_b = '0; m_e = '0;
        reset_n = 1'b0;
        seg_n = 7'h7F;
        dig_n = '1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        apply(4'b1110, 7'h5B, 6);
        chk("first_hex0", {28'd0, hex_out[3:0]}, 32'd2);
        chk("first_valid", {28'd0, digit_valid}, 32'h1);

        apply(4'b1110, 7'h77, 6);
        apply(4'b1101, 7'h7C, 6);
        apply(4'b1011, 7'h39, 6);
        apply(4'b0111, 7'h5E, 6);
        chk("scan_hex", {16'd0, hex_out}, 32'hDCBA);
        chk("scan_valid", {28'd0, digit_valid}, 32'hF);

        apply(4'b1101, 7'h6D, 6);
        apply(4'b1101, 7'h01, 6);
        chk("err_hex1", {28'd0, hex_out[7:4]}, 32'd5);
        chk("err_bits", {28'd0, digit_err}, 32'h2);
        chk("err_valid1", {31'd0, digit_valid[1]}, 32'd0);
        apply(4'b1101, 7'h00, 6);
        chk("blank_bits", {28'd0, digit_blank}, 32'h2);
        chk("blank_err1", {31'd0, digit_err[1]}, 32'd0);
        chk_state("after_blank");

        apply(4'b1110, 7'h3F, 3);
        apply(4'b1110, 7'h06, 3);
        apply(4'b1110, 7'h5B, 3);
        apply(4'b1110, 7'h4F, 3);
        apply(4'b1100, 7'h66, 10);
        chk_state("nocap");

        apply(4'b1011, 7'h7D, N);
        apply(4'b1011, 7'h07, N);
        chk_state("dwell_n");
        apply(4'b1011, 7'h7D, N + 1);
        chk_state("dwell_n1");

        apply(4'b0111, 7'h7F, 3);
        reset_n = 1'b0;
        #1;
        m_hex = '0; m_v = '0; m_b = '0; m_e = '0;
        chk_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        expect_cap(4'b0111, 7'h7F, cyc + 1 + N);
        repeat (6) @(negedge clk);
        chk("post_hex", {16'd0, hex_out}, 32'h8000);
        chk("post_valid", {28'd0, digit_valid}, 32'h8);

        repeat (10) @(negedge clk);
        chk("pending", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Receive-side counterpart to the hex-to-seven-segment encoder. Watches a multiplexed, active-low seven-segment display bus (segment lines plus one-hot active-low digit selects), waits until each digit's pattern has been stable for a programmable number of cycles, then decodes it back to a 4-bit hex value per digit. Used for display loopback checking and for reading scanned displays back into the datapath. Segment patterns that are not a legal digit are flagged as errors.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits, range 1–8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a capture, range 1–255.

- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `seg_n` input 7: segment lines, active-low; bit0 = a … bit6 = g.
- `dig_n` input NUM_DIGITS: digit selects, active-low; a valid select has exactly one bit low.
- `hex_out` output 4*NUM_DIGITS: decoded nibble for digit i, at bits [4i+3:4i].
- `digit_valid` output NUM_DIGITS: 1 = last capture of digit i was a legal hex code.
- `digit_blank` output NUM_DIGITS: 1 = last capture of digit i was all segments off.
- `digit_err` output NUM_DIGITS: 1 = last capture of digit i was neither legal nor blank.
- `cap_stb` output 1: one-cycle pulse when any capture occurs.
- `cap_idx` output 3: index of the captured digit; valid while `cap_stb` = 1 and held afterwards.

## Operation
- **Input register.** `s_seg`/`s_dig` sample `seg_n`/`dig_n` every cycle. Reset values: `s_seg` = 7'h7F, `s_dig` = all ones.
- **Stability counter.** 8 bits wide, saturates at 255.
  - Incoming sample ≠ (`s_seg`, `s_dig`): load 1 if incoming `dig_n` is one-hot-low, else 0.
  - Incoming sample equal and counter ≠ 0: increment.
- **State machine**
  - IDLE: counter = 0, or the select is not one-hot (zero or several digits low). Nothing is captured.
  - COUNT: counter is between 1 and STABLE_CYCLES−1 inclusive.
  - CAPTURE: counter = STABLE_CYCLES. Update digit i = index of the low bit of `s_dig`, pulse `cap_stb`, then go to HOLD.
  - HOLD: no further captures until the sample changes. Any change goes to COUNT (one-hot) or IDLE (not one-hot).
- **Decode.** Uses active-high pattern p = ~`s_seg`, written gfedcba.
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - Legal code: `hex_out[i]` = value, valid = 1, blank = 0, err = 0.
  - p = 0000000: `hex_out[i]` unchanged, valid = 0, blank = 1, err = 0.
  - Any other pattern: `hex_out[i]` unchanged, valid = 0, blank = 0, err = 1.
- A capture touches only digit i; all other digits hold their values.
- Reset mid-window: every register returns to its reset value immediately; no `cap_stb` is produced.

## Timing
- **Reset values.** `hex_out` = 0, `digit_valid` = 0, `digit_blank` = 0, `digit_err` = 0, `cap_stb` = 0, `cap_idx` = 0.
- **Capture latency.** If inputs are first sampled at edge k and held, the counter is 1 after edge k and reaches STABLE_CYCLES after edge k+STABLE_CYCLES−1. Outputs and `cap_stb` update at edge k+STABLE_CYCLES. `cap_stb` is high for exactly one cycle.
- **STABLE_CYCLES = 1.** Capture occurs at edge k+1.
- **Input change.** A change in either `seg_n` or `dig_n` at any point before the capture edge restarts the count.
- **Simultaneous change.** A segment and select change together count as one change: the window restarts for the new digit.
- **Continuous scanning.** Digits scanned with dwell ≥ STABLE_CYCLES+1 cycles are each captured once per dwell. If dwell ≤ STABLE_CYCLES, no capture ever happens.

## Test plan
- Reset, then hold `dig_n` = 4'b1110 and `seg_n` = ~7'b1011011 for 6 cycles (STABLE_CYCLES = 4) → `hex_out[3:0]` = 2, `digit_valid` = 4'b0001, and one `cap_stb` at edge k+4 with `cap_idx` = 0.
- Scan digits 0–3 with codes 0xA, 0xb, 0xC, 0xd, dwell 6 cycles each → `hex_out` = 16'hDCBA, `digit_valid` = 4'hF, and exactly 4 `cap_stb` pulses with `cap_idx` = 0, 1, 2, 3.
- Digit 1 shows 0x5, then is rescanned with pattern 0000001 → digit 1 keeps `hex_out` = 5, `digit_err[1]` = 1, `digit_valid[1]` = 0. Rescanned with all segments off → `digit_blank[1]` = 1, `digit_err[1]` = 0.
- Change `seg_n` every 3 cycles with STABLE_CYCLES = 4; also drive `dig_n` = 4'b1100 (two digits low) for 10 cycles → no `cap_stb` and all outputs unchanged.
- Assert `reset_n` low asynchronously after 3 stable cycles of a window → all outputs 0 immediately, no capture. Release reset and hold inputs → capture occurs 4 edges after the first post-reset edge.
